register_file: RTL and testbench

//  - MIPS-style general-purpose register file: 32 x 32-bit registers, two read ports, one write port.
//  - Sits in the decode stage of the MIPS datapath.
//    - Read ports supply rs/rt operands.
//    - Write port is driven by the writeback stage.
//  - Register 0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/register_file_if.sv | 29 ++
 rtl/regfile_read_port.sv | 37 +++
 rtl/register_file.sv | 63 ++++++
 tb/tb_register_file.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_pkg : shared sizes, zero-register index and typedefs       |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/register_file_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | register_file_if : read/write port bundle of the register file     |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
interface register_file_if
  import regfile_pkg::*;
();

  reg_addr_t read1;
  reg_addr_t read2;
  reg_addr_t reg_write;
  reg_data_t wdata;
  logic      write;
  reg_data_t data1;
  reg_data_t data2;

  modport master (
    output read1, read2, reg_write, wdata, write,
    input  data1, data2
  );

  modport slave (
    input  read1, read2, reg_write, wdata, write,
    output data1, data2
  );

endinterface : register_file_if
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_read_port : async read mux, r0 forced to zero, optional    |
// | write-through bypass under REGFILE_WRITE_BYPASS_EN. Revision 1.0   |
// +--------------------------------------------------------------------+
module regfile_read_port
  import regfile_pkg::*;
(
  input  reg_data_t regs_i [NUM_REGS],
  input  reg_addr_t raddr_i,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  reg_addr_t waddr_i,
  input  reg_data_t wdata_i,
  input  logic      we_i,
`endif
  output reg_data_t rdata_o
);

  reg_data_t w_rdata;

  always_comb begin
    w_rdata = regs_i[raddr_i];
`ifdef REGFILE_WRITE_BYPASS_EN
    // Forward the in-flight write so the reader sees it before the edge commits it.
    if (we_i && (waddr_i != ZERO_REG) && (raddr_i == waddr_i)) begin
      w_rdata = wdata_i;
    end
`endif
    if (raddr_i == ZERO_REG) begin
      w_rdata = '0;
    end
  end

  assign rdata_o = w_rdata;

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | register_file : 32x32 MIPS GPR file, 2 async reads, 1 sync write;  |
// | bypass option REGFILE_WRITE_BYPASS_EN. Revision 1.0                |
// +--------------------------------------------------------------------+
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  register_file_if.slave     bus
);

  if (NUM_REGS != (2 ** ADDR_W)) begin : g_size_check
    $error("register_file: NUM_REGS must equal 2**ADDR_W");
  end

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    // Index 0 never has a write enable, so it stays at its reset value of zero.
    logic w_we;
    assign w_we = bus.write && (i != 0) && (bus.reg_write == ADDR_W'(i));
    assign regs_d[i] = w_we ? bus.wdata : regs_q[i];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  regfile_read_port u_rd1 (
    .regs_i  (regs_q),
    .raddr_i (bus.read1),
`ifdef REGFILE_WRITE_BYPASS_EN
    .waddr_i (bus.reg_write),
    .wdata_i (bus.wdata),
    .we_i    (bus.write),
`endif
    .rdata_o (bus.data1)
  );

  regfile_read_port u_rd2 (
    .regs_i  (regs_q),
    .raddr_i (bus.read2),
`ifdef REGFILE_WRITE_BYPASS_EN
    .waddr_i (bus.reg_write),
    .wdata_i (bus.wdata),
    .we_i    (bus.write),
`endif
    .rdata_o (bus.data2)
  );

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_register_file : randomized bench with array reference model     |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_register_file;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] model [32];

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] wa, input logic [31:0] wd, input logic we);
    bus.read1     = r1;
    bus.read2     = r2;
    bus.reg_write = wa;
    bus.wdata     = wd;
    bus.write     = we;
  endtask

  // Advance one rising edge and apply the architectural effect to the model.
  task automatic clock_edge();
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) model[k] = 32'h0;
    end else if (bus.write && bus.reg_write != 5'd0) begin
      model[bus.reg_write] = bus.wdata;
    end
    #1;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && bus.write && bus.reg_write != 5'd0 && a == bus.reg_write) return bus.wdata;
    return model[a];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 5'd5, $urandom, 1'b1);
    clock_edge();
    clock_edge();
    rst_n = 1'b1;
    drive(5'd8, 5'd31, 5'd0, 32'h0, 1'b0);
    #1;
    checks++;
    if (bus.data1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_data1 got=%h exp=%h", bus.data1, 32'h0);
    end
    checks++;
    if (bus.data2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_data2 got=%h exp=%h", bus.data2, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      bus.read1 = 5'(i);
      bus.read2 = 5'(31 - i);
      #1;
      checks++;
      if (bus.data1 !== 32'h0 || bus.data2 !== 32'h0) begin
        failures++;
        $display("FAIL reset_sweep idx=%0d got1=%h got2=%h exp=0", i, bus.data1, bus.data2);
      end
    end
  endtask

  task automatic test_basic_write();
    drive(5'd0, 5'd8, 5'd8, 32'h0000000F, 1'b1);
    clock_edge();
    bus.write = 1'b0;
    #1;
    checks++;
    if (bus.data2 !== 32'h0000000F) begin
      failures++;
      $display("FAIL basic_write_r8 got=%h exp=%h", bus.data2, 32'h0000000F);
    end
    drive(5'd3, 5'd0, 5'd3, 32'h00000007, 1'b1);
    clock_edge();
    bus.write = 1'b0;
    #1;
    checks++;
    if (bus.data1 !== 32'h00000007) begin
      failures++;
      $display("FAIL basic_write_r3 got=%h exp=%h", bus.data1, 32'h00000007);
    end
  endtask

  task automatic test_write_disabled();
    drive(5'd8, 5'd3, 5'd8, 32'h00000007, 1'b0);
    clock_edge();
    checks++;
    if (bus.data1 !== 32'h0000000F) begin
      failures++;
      $display("FAIL write_disabled_r8 got=%h exp=%h", bus.data1, 32'h0000000F);
    end
    checks++;
    if (bus.data2 !== 32'h00000007) begin
      failures++;
      $display("FAIL write_disabled_r3 got=%h exp=%h", bus.data2, 32'h00000007);
    end
  endtask

  task automatic test_zero_reg();
    drive(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
    #1;
    checks++;
    if (bus.data1 !== 32'h0 || bus.data2 !== 32'h0) begin
      failures++;
      $display("FAIL zero_reg_pre got1=%h got2=%h exp=0", bus.data1, bus.data2);
    end
    clock_edge();
    bus.write = 1'b0;
    #1;
    checks++;
    if (bus.data1 !== 32'h0 || bus.data2 !== 32'h0) begin
      failures++;
      $display("FAIL zero_reg_post got1=%h got2=%h exp=0", bus.data1, bus.data2);
    end
  endtask

  task automatic test_same_cycle();
    drive(5'd8, 5'd1, 5'd1, 32'h00000003, 1'b1);
    #1;
    checks++;
    if (bus.data2 !== (BYPASS ? 32'h3 : 32'h0)) begin
      failures++;
      $display("FAIL same_cycle_pre got=%h exp=%h", bus.data2, (BYPASS ? 32'h3 : 32'h0));
    end
    checks++;
    if (bus.data1 !== 32'h0000000F) begin
      failures++;
      $display("FAIL same_cycle_other_port got=%h exp=%h", bus.data1, 32'h0000000F);
    end
    clock_edge();
    bus.write = 1'b0;
    #1;
    checks++;
    if (bus.data2 !== 32'h00000003) begin
      failures++;
      $display("FAIL same_cycle_post got=%h exp=%h", bus.data2, 32'h00000003);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      drive(5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) bus.read1 = bus.reg_write;
      if ($urandom_range(0, 3) == 0) bus.read2 = bus.read1;
      #1;
      checks++;
      if (bus.data1 !== exp_read(bus.read1)) begin
        failures++;
        $display("FAIL random_data1 n=%0d idx=%0d got=%h exp=%h", n, bus.read1, bus.data1, exp_read(bus.read1));
      end
      checks++;
      if (bus.data2 !== exp_read(bus.read2)) begin
        failures++;
        $display("FAIL random_data2 n=%0d idx=%0d got=%h exp=%h", n, bus.read2, bus.data2, exp_read(bus.read2));
      end
      clock_edge();
    end
    rst_n = 1'b1;
    bus.write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.read1 = 5'(i);
      #1;
      checks++;
      if (bus.data1 !== exp_read(bus.read1)) begin
        failures++;
        $display("FAIL random_sweep idx=%0d got=%h exp=%h", i, bus.data1, exp_read(bus.read1));
      end
    end
  endtask

  task automatic test_reset_midrun();
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 5'd1, 32'h00000003, 1'b1);
    clock_edge();
    drive(5'd0, 5'd0, 5'd3, 32'h00000007, 1'b1);
    clock_edge();
    drive(5'd0, 5'd0, 5'd8, 32'h0000000F, 1'b1);
    clock_edge();
    drive(5'd1, 5'd3, 5'd8, 32'hA5A5A5A5, 1'b0);
    #1;
    checks++;
    if (bus.data1 !== 32'h3 || bus.data2 !== 32'h7) begin
      failures++;
      $display("FAIL midrun_preload got1=%h got2=%h exp1=3 exp2=7", bus.data1, bus.data2);
    end
    rst_n = 1'b0;
    bus.write = 1'b1;
    clock_edge();
    rst_n = 1'b1;
    bus.write = 1'b0;
    #1;
    checks++;
    if (bus.data1 !== 32'h0 || bus.data2 !== 32'h0) begin
      failures++;
      $display("FAIL midrun_r1_r3 got1=%h got2=%h exp=0", bus.data1, bus.data2);
    end
    bus.read1 = 5'd8;
    #1;
    checks++;
    if (bus.data1 !== 32'h0) begin
      failures++;
      $display("FAIL midrun_r8 got=%h exp=%h", bus.data1, 32'h0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    #2;
    test_reset();
    test_basic_write();
    test_write_disabled();
    test_zero_reg();
    test_same_cycle();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_file
`default_nettype wire
